// File: rtl/spi_payload_tx_pkg.sv
// spi_payload_tx_pkg: constants and types shared by the SPI payload transmitter.
//   - preamble and trailer byte values, framed MSB first on MOSI
//   - default frame geometry, which the receiving end uses as well
//   - transmitter state encoding
package spi_payload_tx_pkg;

  localparam logic [7:0] PREAMBLE_0   = 8'h00;
  localparam logic [7:0] PREAMBLE_1   = 8'hFF;
  localparam logic [7:0] TRAILER_BYTE = 8'h00;

  localparam int DEF_CLK_DIV       = 20;
  localparam int DEF_PAYLOAD_BYTES = 90;
  localparam int DEF_TRAILER_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STALL = 3'd3,
    ST_HOLD  = 3'd4
  } tx_state_e;

  // Serial bits in one frame: two preamble bytes, payload, trailer.
  function automatic int frame_bits(input int payload, input int trailer);
    return 8 * (2 + payload + trailer);
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: counts CLK_DIV cycles of CLK_40 per SPI half-period.
//   CLK_40  system clock
//   reset   synchronous, active low
//   run     count this cycle (low = frozen)
//   clear   force the count back to zero (restart a full half-period)
//   tc      terminal-count strobe, high in the last cycle of a half-period
module spi_half_period_timer #(
  parameter int CLK_DIV = 20
) (
  input  logic CLK_40,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tc
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = run && (cnt_q == LAST);

  always_ff @(posedge CLK_40) begin
    if (!reset)     cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (run)   cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/spi_payload_tx.sv
// spi_payload_tx: SPI mode-0 master that sends one framed payload per start.
// Frame = 0x00 0xFF, PAYLOAD_BYTES from the byte stream, TRAILER_BYTES of 0x00.
//   CLK_40       system clock (only clock)
//   reset        synchronous, active low
//   start        one-cycle frame request, honoured only in IDLE
//   byte_data    payload byte, byte_valid qualifies it
//   byte_ready   block takes byte_data this cycle (decoded from registers)
//   SPI_clk      serial clock, idles low
//   MOSI         serial data, MSB first, changes only while SPI_clk is low
//   chip_select  active-low frame enable
//   busy         frame in progress
//   stalled      shifting paused waiting for a payload byte
//   done         one-cycle end-of-frame pulse
module spi_payload_tx
  import spi_payload_tx_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int TRAILER_BYTES = DEF_TRAILER_BYTES
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       SPI_clk,
  output logic       MOSI,
  output logic       chip_select,
  output logic       busy,
  output logic       stalled,
  output logic       done
);

  localparam int N_BITS    = frame_bits(PAYLOAD_BYTES, TRAILER_BYTES);
  localparam int BIT_W     = $clog2(N_BITS + 1);
  localparam int FETCH_W   = $clog2(PAYLOAD_BYTES + 1);
  localparam int PAY_FIRST = 2;
  localparam int PAY_END   = 2 + PAYLOAD_BYTES;

  tx_state_e          state_q, state_d;
  logic [7:0]         sr_q, sr_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FETCH_W-1:0] fetch_q, fetch_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               stalled_q, stalled_d;
  logic               done_q, done_d;

  logic             tc, run, clr, xfer, load_hold;
  logic [BIT_W-1:0] nxt_bits;
  logic [31:0]      nxt_byte;
  logic             at_byte, last_bit, nxt_payload;
  logic [7:0]       nxt_const;

  // Timer runs in every timed state; frozen in STALL, restarted on leaving it
  // so the low half after a stall is a full CLK_DIV long.
  assign run = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign clr = (state_q == ST_IDLE) || ((state_q == ST_STALL) && hold_full_q);

  spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .CLK_40 (CLK_40),
    .reset  (reset),
    .run    (run),
    .clear  (clr),
    .tc     (tc)
  );

  // Decode of what the next falling edge completes.
  assign nxt_bits    = bit_cnt_q + BIT_W'(1);
  assign nxt_byte    = 32'(nxt_bits >> 3);
  assign at_byte     = (nxt_bits[2:0] == 3'd0);
  assign last_bit    = (nxt_bits == BIT_W'(N_BITS));
  assign nxt_payload = (nxt_byte >= 32'(PAY_FIRST)) && (nxt_byte < 32'(PAY_END));
  assign nxt_const   = (nxt_byte == 32'd1) ? PREAMBLE_1 : TRAILER_BYTE;

  assign byte_ready = busy_q && !hold_full_q && (fetch_q != FETCH_W'(PAYLOAD_BYTES));
  assign xfer       = byte_valid && byte_ready;

  assign SPI_clk     = sclk_q;
  assign MOSI        = sr_q[7];
  assign chip_select = cs_q;
  assign busy        = busy_q;
  assign stalled     = stalled_q;
  assign done        = done_q;

  // State register
  always_ff @(posedge CLK_40) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (tc) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (tc && sclk_q) begin
          if (last_bit)                                   state_d = ST_HOLD;
          else if (at_byte && nxt_payload && !hold_full_q) state_d = ST_STALL;
        end
      end
      ST_STALL: if (hold_full_q) state_d = ST_SHIFT;
      ST_HOLD:  if (tc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    fetch_d     = fetch_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_hold   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          sr_d      = PREAMBLE_0;
          bit_cnt_d = '0;
          fetch_d   = '0;
        end
      end
      ST_SETUP: if (tc) sclk_d = 1'b1;
      ST_SHIFT: begin
        if (tc) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // falling edge: present the next bit in the same cycle
            sclk_d    = 1'b0;
            bit_cnt_d = nxt_bits;
            if (!last_bit) begin
              if (!at_byte) begin
                sr_d = {sr_q[6:0], 1'b0};
              end else if (!nxt_payload) begin
                sr_d = nxt_const;
              end else if (hold_full_q) begin
                sr_d      = hold_q;
                load_hold = 1'b1;
              end
              // payload byte missing: sr holds, MOSI keeps its last bit
            end
          end
        end
      end
      ST_STALL: begin
        if (hold_full_q) begin
          sr_d      = hold_q;
          load_hold = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tc) begin
          cs_d   = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
          sr_d   = '0;
        end
      end
      default: ;
    endcase

    // A fresh byte may land in the same cycle the old one moves to sr.
    if (xfer) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
      if (fetch_q != FETCH_W'(PAYLOAD_BYTES)) fetch_d = fetch_q + FETCH_W'(1);
    end else if (load_hold) begin
      hold_full_d = 1'b0;
    end

    // Flag only the cycles still waiting; the reload cycle is not stalled.
    stalled_d = (state_d == ST_STALL) && !hold_full_d;
  end

  always_ff @(posedge CLK_40) begin
    if (!reset) begin
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      fetch_q     <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      stalled_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      fetch_q     <= fetch_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      stalled_q   <= stalled_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_payload_tx.sv
// tb_spi_payload_tx: frame-level reference model for spi_payload_tx.
// Expected edge times come from the nominal schedule plus the delay each
// late payload byte imposes at its boundary; bytes are rebuilt from MOSI.
module tb_spi_payload_tx;

  localparam int CD = 4;
  localparam int PB = 2;
  localparam int TB = 3;
  localparam int NB = 8 * (2 + PB + TB);
  localparam int NBY = NB / 8;
  localparam int NEVER = 32'h3FFF_FFFF;

  logic       CLK_40 = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready, SPI_clk, MOSI, chip_select, busy, stalled, done;

  spi_payload_tx #(.CLK_DIV(CD), .PAYLOAD_BYTES(PB), .TRAILER_BYTES(TB)) dut (
    .CLK_40      (CLK_40),
    .reset       (reset),
    .start       (start),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .SPI_clk     (SPI_clk),
    .MOSI        (MOSI),
    .chip_select (chip_select),
    .busy        (busy),
    .stalled     (stalled),
    .done        (done)
  );

  always #5 CLK_40 = ~CLK_40;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_end = 0;
  logic [7:0] pay [PB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK_40);
    #1;
    cyc++;
  endtask

  // mode 0: byte_valid high throughout; 1: withhold until 37th stalled cycle;
  // 2: random byte_valid.
  task automatic run_frame(input int mode, input bit b2b, input bit mid_start);
    int t0, c, c_end, rises, exp_rise, exp_end, stall_cnt, exp_stall;
    int ndone, pidx, late_rdy, last_chg, f, k, tj, e;
    int xt [PB];
    logic [7:0] rx [NBY];
    logic [7:0] eb;
    logic psclk, pmosi;

    if (!b2b) begin
      repeat (3) begin
        step();
        chk("idle_cs", chip_select, 1);
        chk("idle_done", done, 0);
        chk("idle_rdy", byte_ready, 0);
      end
    end else begin
      step();
    end
    start = 1'b1;
    byte_valid = (mode == 0);
    byte_data = pay[0];
    step();
    start = 1'b0;
    t0 = cyc;
    if (b2b) chk("b2b_t0", t0, last_end + 2);
    chk("t0_cs", chip_select, 0);
    chk("t0_busy", busy, 1);

    c_end = -1; rises = 0; exp_rise = 0; stall_cnt = 0; exp_stall = 0;
    ndone = 0; pidx = 0; late_rdy = 0; last_chg = t0;
    for (int i = 0; i < PB; i++) xt[i] = NEVER;
    for (int i = 0; i < NBY; i++) rx[i] = 8'h00;
    psclk = 1'b0;
    pmosi = MOSI;

    for (int g = 0; g < 3000; g++) begin
      if (g > 0) step();
      c = cyc;
      if (SPI_clk && !psclk) begin
        k = rises;
        if (k == 0) begin
          exp_rise = t0 + CD;
        end else begin
          f = exp_rise + CD;
          if ((k % 8 == 0) && (k / 8 >= 2) && (k / 8 < 2 + PB)) begin
            tj = xt[k / 8 - 2];
            if (tj <= f - 2) begin
              exp_rise = f + CD;
            end else begin
              e = (tj + 1 > f) ? tj + 1 : f;
              exp_rise = e + 1 + CD;
              if (tj - f + 1 > 0) exp_stall += tj - f + 1;
            end
          end else begin
            exp_rise = f + CD;
          end
        end
        chk("rise_t", c, exp_rise);
        chk("setup", 32'(c - last_chg >= CD), 1);
        if (k < NB) rx[k / 8][7 - (k % 8)] = MOSI;
        rises++;
      end
      if (MOSI !== pmosi) begin
        chk("mosi_low", SPI_clk, 0);
        last_chg = c;
      end
      if (stalled) begin
        stall_cnt++;
        chk("stall_sclk", SPI_clk, 0);
      end
      if (done) ndone++;
      if (chip_select) begin
        c_end = c;
        break;
      end
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = byte_valid || (stalled && stall_cnt >= 37);
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_data = (pidx < PB) ? pay[pidx] : 8'($urandom);
      if (pidx >= PB && byte_ready) late_rdy++;
      if (byte_valid && byte_ready) begin
        if (pidx < PB) xt[pidx] = c;
        pidx++;
      end
      start = mid_start && (c == t0 + 50);
      psclk = SPI_clk;
      pmosi = MOSI;
    end
    byte_valid = 1'b0;
    start = 1'b0;

    if (c_end < 0) begin
      chk("timeout", 0, 1);
      return;
    end
    last_end = c_end;
    exp_end = exp_rise + 2 * CD;
    chk("cs_rise", c_end, exp_end);
    chk("done_end", done, 1);
    chk("done_cnt", ndone, 1);
    chk("busy_end", busy, 0);
    chk("nbits", rises, NB);
    chk("xfers", pidx, PB);
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("late_rdy", late_rdy, 0);
    for (int i = 0; i < NBY; i++) begin
      eb = (i == 1) ? 8'hFF : ((i >= 2 && i < 2 + PB) ? pay[i - 2] : 8'h00);
      chk($sformatf("byte%0d", i), rx[i], eb);
    end
    if (mode == 0) begin
      chk("len", c_end - t0, CD * (2 * NB + 1));
      chk("prefetch", xt[0], t0);
    end
    if (mode == 1) begin
      chk("len_stall", c_end - t0, CD * (2 * NB + 1) + 38);
      chk("stall37", stall_cnt, 37);
    end
  endtask

  // Reset at the 100th busy cycle of a frame.
  task automatic abort_frame();
    int bcnt;
    bcnt = 0;
    step();
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'($urandom);
    step();
    start = 1'b0;
    for (int g = 0; g < 1000; g++) begin
      if (g > 0) step();
      if (busy) bcnt++;
      if (bcnt == 100) begin
        reset = 1'b0;
        break;
      end
    end
    chk("abort_reached", bcnt, 100);
    step();
    chk("abort_cs", chip_select, 1);
    chk("abort_sclk", SPI_clk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdy", byte_ready, 0);
    reset = 1'b1;
    byte_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) step();
    chk("rst_cs", chip_select, 1);
    chk("rst_sclk", SPI_clk, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_rdy", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;

    pay[0] = 8'hA5; pay[1] = 8'h3C;
    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);

    pay[0] = 8'($urandom); pay[1] = 8'($urandom);
    run_frame(0, 1'b0, 1'b1);

    abort_frame();
    pay[0] = 8'($urandom); pay[1] = 8'($urandom);
    run_frame(0, 1'b0, 1'b0);

    pay[0] = 8'($urandom); pay[1] = 8'($urandom);
    run_frame(2, 1'b1, 1'b0);

    repeat (3) begin
      pay[0] = 8'($urandom); pay[1] = 8'($urandom);
      run_frame(2, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_payload_tx.md
# spi_payload_tx

SPI-mode-0 master transmitter that serializes one framed video payload onto `MOSI`, generating `SPI_clk` and `chip_select` from `CLK_40`. Each frame is a fixed sequence: preamble `0x00 0xFF`, `PAYLOAD_BYTES` bytes taken from a valid/ready byte stream, then `TRAILER_BYTES` bytes of `0x00`, all MSB first. It is the transmit end of the payload link that `FSM_top` receives on `MISO_CDC`, and is used for board loopback and bench stimulus generation.

## Interface
- `CLK_DIV`, default 20: `CLK_40` cycles per SPI half-period (20 gives 1 MHz); minimum 2.
- `PAYLOAD_BYTES`, default 90: payload bytes per frame (15 frames × 6 bytes); minimum 1.
- `TRAILER_BYTES`, default 3: zero bytes appended after the payload; minimum 0.
- `CLK_40`  in  1  system clock, 40 MHz; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `byte_data`  in  8  payload byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  block accepts `byte_data` this cycle (transfer = valid & ready).
- `SPI_clk`  out  1  serial clock, idles low.
- `MOSI`  out  1  serial data; changes only while `SPI_clk` is low.
- `chip_select`  out  1  active-low frame enable.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `stalled`  out  1  shift paused waiting for a payload byte.
- `done`  out  1  one-cycle pulse when the frame ends.

## Operation
- Reset values (reset low): `SPI_clk`=0, `MOSI`=0, `chip_select`=1, `byte_ready`=0, `busy`=0, `stalled`=0, `done`=0. Hold register empty; counters at 0. Reset mid-frame aborts on the next edge without a `done` pulse.
- States: IDLE → SETUP → SHIFT ⇄ STALL → HOLD → IDLE.
- IDLE: `start`=1 → SETUP. `chip_select`=0, `MOSI`=bit 7 of `0x00`, `SPI_clk`=0. `start` is ignored in every other state.
- SETUP: lasts `CLK_DIV` cycles, then `SPI_clk` rises → SHIFT.
- SHIFT: `SPI_clk` toggles every `CLK_DIV` cycles. On each falling edge, `MOSI` takes the next bit in the same cycle.
- At a byte boundary (falling edge after bit 0), the next byte is loaded from its source:
  - preamble: constants;
  - payload: hold register;
  - trailer: `0x00`.
- If the next byte is payload and the hold register is empty → STALL. `SPI_clk` stays 0, `MOSI` holds its last bit, the half-period counter is frozen, and `stalled`=1.
- STALL exit: in the first cycle the hold register is full, load the shift register, set `MOSI` to bit 7, empty the hold register and return to SHIFT. The low half restarts with a full `CLK_DIV` cycles.
- After the falling edge of the last bit → HOLD. `SPI_clk`=0 for `CLK_DIV` cycles. Then `chip_select`=1 and `done`=1 for one cycle, `busy`=0, → IDLE.
- Hold register is one byte:
  - `byte_ready` = `busy` & hold empty & payload bytes still to fetch.
  - Prefetch is allowed from the first busy cycle.
  - A transfer and a same-cycle shift-register load from the hold register are legal. The hold register is then filled in that cycle.
- Payload fetch counter: width $clog2(`PAYLOAD_BYTES`+1). It counts accepted bytes and saturates at `PAYLOAD_BYTES`, so `byte_ready` never rises after the last payload byte.
- Total bits per frame: N = 8×(2+`PAYLOAD_BYTES`+`TRAILER_BYTES`). Bit counter width $clog2(N+1).

## Timing
- Let t0 be the cycle `chip_select` falls; t0 is one cycle after `start` is sampled.
- With no stalls:
  - bit i rising edge at t0+`CLK_DIV`×(2i+1);
  - last falling edge at t0+`CLK_DIV`×2N;
  - `chip_select` rises and `done` pulses at t0+`CLK_DIV`×(2N+1).
- Each stall delays all later edges by (stall cycles + 1).
- `MOSI` is stable for ≥ `CLK_DIV` cycles before every rising edge and throughout the high phase.
- All outputs are registered except `byte_ready`, which is decoded from registers only and has no input-to-output path.

## Structure
- Shared `params.sv` holds: preamble bytes `0x00`/`0xFF`, default `PAYLOAD_BYTES` = 90 and `TRAILER_BYTES` = 3 (same defines the receiver uses), and the state enum.
- Sub-module `spi_half_period_timer`: `CLK_DIV` counter with enable/freeze/restart, emitting a terminal-count strobe.
- Top level holds the FSM, shift register, hold register and counters.

## Test plan
- Bench parameters: `CLK_DIV`=4, `PAYLOAD_BYTES`=2, `TRAILER_BYTES`=3.
- Basic frame: `start` with `A5`, `3C` pre-offered → `MOSI` sampled on `SPI_clk` rises reads `00 FF A5 3C 00 00 00`. `chip_select` low for exactly 452 cycles; one `done` pulse.
- Stall: withhold `byte_valid` for 37 cycles at the `FF`→payload boundary → `stalled`=1 for 37 cycles with `SPI_clk`=0. Frame length is 452+38 cycles and data is identical.
- Handshake: `byte_valid` held high throughout → exactly 2 transfers. `byte_ready` stays 0 after the second transfer until the next `start`.
- `start` pulsed mid-frame → ignored: a single frame and a single `done`.
- Reset low at the 100th busy cycle → next edge `chip_select`=1, `SPI_clk`=0, `busy`=0, no `done`. A following `start` produces a full correct frame.
- Back-to-back: `start` in the cycle after `done` → second frame with t0 two cycles after `done`, correct bytes.
